// File: rtl/aib_avmm_cfg_sequencer.sv
// Replays a constant table of Avalon-MM configuration writes after calibration start,
// with optional read-back verify, bounded retries and a per-state watchdog.
module aib_avmm_cfg_sequencer #(
  parameter int unsigned                   NUM_ENTRIES    = 4,
  parameter logic [NUM_ENTRIES*17-1:0]     CFG_ADDR_TABLE = '0,
  parameter logic [NUM_ENTRIES*32-1:0]     CFG_DATA_TABLE = '0,
  parameter bit                            VERIFY_EN      = 1'b0,
  parameter int unsigned                   MAX_RETRY      = 3,
  parameter int unsigned                   TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_idx,
  output logic [16:0] avmm_address,
  output logic [31:0] avmm_writedata,
  output logic [3:0]  avmm_byteenable,
  output logic        avmm_write,
  output logic        avmm_read,
  input  logic [31:0] avmm_readdata,
  input  logic        avmm_readdatavalid,
  input  logic        avmm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam int unsigned     IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int unsigned     TBL_DEPTH   = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [3:0]      RETRY_LIMIT = 4'(MAX_RETRY);
  localparam logic [15:0]     TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         retry_q, retry_d;
  logic [15:0]        tmr_q, tmr_d;

  logic [16:0]        addr_rom [TBL_DEPTH];
  logic [31:0]        data_rom [TBL_DEPTH];
  logic [16:0]        cur_addr;
  logic [31:0]        cur_data;
  logic               bus_state;

  // Table padded to a power of two so idx never indexes outside the array.
  for (genvar g = 0; g < TBL_DEPTH; g++) begin : g_tbl
    if (g < NUM_ENTRIES) begin : g_used
      assign addr_rom[g] = CFG_ADDR_TABLE[17*g +: 17];
      assign data_rom[g] = CFG_DATA_TABLE[32*g +: 32];
    end else begin : g_pad
      assign addr_rom[g] = '0;
      assign data_rom[g] = '0;
    end
  end

  assign cur_addr  = addr_rom[idx_q];
  assign cur_data  = data_rom[idx_q];
  assign bus_state = (state_q == S_WRITE) || (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      retry_q <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tmr_q   <= tmr_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      S_WRITE: begin
        if (!avmm_waitrequest) begin
          if (VERIFY_EN) begin
            state_d = S_RD_REQ;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            retry_d = '0;
          end
        end
      end
      S_RD_REQ: begin
        if (!avmm_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (avmm_readdatavalid) begin
          if (avmm_readdata == cur_data) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WRITE;
              idx_d   = idx_q + 1'b1;
              retry_d = '0;
            end
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RETRY_LIMIT) ? S_ERR : S_WRITE;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog only fires when the bus state would otherwise make no progress.
    if (bus_state && (state_d == state_q) && (idx_d == idx_q) && (tmr_q == TMO_LAST)) begin
      state_d = S_ERR;
    end

    if (!bus_state || (state_d != state_q) || (idx_d != idx_q)) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  // Outputs depend on registered state only, so they stay stable under waitrequest.
  always_comb begin
    done            = 1'b0;
    error           = 1'b0;
    err_idx         = '0;
    avmm_address    = '0;
    avmm_writedata  = '0;
    avmm_byteenable = 4'h0;
    avmm_write      = 1'b0;
    avmm_read       = 1'b0;
    unique case (state_q)
      S_WRITE: begin
        avmm_write      = 1'b1;
        avmm_address    = cur_addr;
        avmm_writedata  = cur_data;
        avmm_byteenable = 4'hF;
      end
      S_RD_REQ: begin
        avmm_read       = 1'b1;
        avmm_address    = cur_addr;
        avmm_byteenable = 4'hF;
      end
      S_DONE: begin
        done = 1'b1;
      end
      S_ERR: begin
        done    = 1'b1;
        error   = 1'b1;
        err_idx = 8'(idx_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aib_avmm_cfg_sequencer.sv
// Scoreboard bench: a write-only instance and a verify instance share clock/reset;
// stimulus queues expected bus/done events, a negedge monitor pops and compares them.
module tb_aib_avmm_cfg_sequencer;

  localparam logic [16:0] A0 = 17'h00010, A1 = 17'h01234, A2 = 17'h1FFFF;
  localparam logic [31:0] D0 = 32'h1234_5678, D1 = 32'hCAFE_F00D, D2 = 32'h0000_0001;
  localparam logic [50:0] ADDR_TBL = {A2, A1, A0};
  localparam logic [95:0] DATA_TBL = {D2, D1, D0};

  typedef struct {
    int          dut;
    int          kind;   // 0 write, 1 read, 2 done
    logic [16:0] addr;
    logic [31:0] data;
    int          hold;
    logic        err;
    logic [7:0]  eidx;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_wo, start_vf, wt_wo, wt_vf, rdv_vf, stray_req, corrupt;
  logic [31:0] rdata_vf;

  logic        done_s  [2];
  logic        error_s [2];
  logic [7:0]  eidx_s  [2];
  logic [16:0] addr_s  [2];
  logic [31:0] wd_s    [2];
  logic [3:0]  be_s    [2];
  logic        wr_s    [2];
  logic        rd_s    [2];
  logic        wt_m    [2];

  logic [16:0] a_ref [3] = '{A0, A1, A2};
  logic [31:0] d_ref [3] = '{D0, D1, D2};

  ev_t exp_q[$];
  int  n_vec = 0, n_err = 0, n_ev = 0, cyc_no = 0, k0 = 0;

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_no++; end

  always_comb begin
    wt_m[0] = wt_wo;
    wt_m[1] = wt_vf;
  end

  aib_avmm_cfg_sequencer #(
    .NUM_ENTRIES(3), .CFG_ADDR_TABLE(ADDR_TBL), .CFG_DATA_TABLE(DATA_TBL),
    .VERIFY_EN(1'b0), .MAX_RETRY(3), .TIMEOUT_CYCLES(16)
  ) u_wo (
    .clk(clk), .rst_n(rst_n), .start(start_wo),
    .done(done_s[0]), .error(error_s[0]), .err_idx(eidx_s[0]),
    .avmm_address(addr_s[0]), .avmm_writedata(wd_s[0]), .avmm_byteenable(be_s[0]),
    .avmm_write(wr_s[0]), .avmm_read(rd_s[0]),
    .avmm_readdata(32'h0), .avmm_readdatavalid(1'b0), .avmm_waitrequest(wt_wo)
  );

  aib_avmm_cfg_sequencer #(
    .NUM_ENTRIES(3), .CFG_ADDR_TABLE(ADDR_TBL), .CFG_DATA_TABLE(DATA_TBL),
    .VERIFY_EN(1'b1), .MAX_RETRY(2), .TIMEOUT_CYCLES(16)
  ) u_vf (
    .clk(clk), .rst_n(rst_n), .start(start_vf),
    .done(done_s[1]), .error(error_s[1]), .err_idx(eidx_s[1]),
    .avmm_address(addr_s[1]), .avmm_writedata(wd_s[1]), .avmm_byteenable(be_s[1]),
    .avmm_write(wr_s[1]), .avmm_read(rd_s[1]),
    .avmm_readdata(rdata_vf), .avmm_readdatavalid(rdv_vf), .avmm_waitrequest(wt_vf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input int k, input int i, input int hold,
                      input logic e, input logic [7:0] ei);
    ev_t ev;
    ev.dut  = d;
    ev.kind = k;
    ev.addr = (k < 2) ? a_ref[i] : 17'h0;
    ev.data = (k == 0) ? d_ref[i] : 32'h0;
    ev.hold = hold;
    ev.err  = e;
    ev.eidx = ei;
    exp_q.push_back(ev);
  endtask

  task automatic score(input ev_t g);
    ev_t e;
    n_ev++;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL ev%0d_unexpected: got dut%0d kind%0d addr %h, required no event",
               n_ev, g.dut, g.kind, g.addr);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("ev%0d_dut", n_ev),  g.dut,  e.dut);
      check($sformatf("ev%0d_kind", n_ev), g.kind, e.kind);
      check($sformatf("ev%0d_addr", n_ev), g.addr, e.addr);
      check($sformatf("ev%0d_data", n_ev), g.data, e.data);
      check($sformatf("ev%0d_hold", n_ev), g.hold, e.hold);
      check($sformatf("ev%0d_err", n_ev),  g.err,  e.err);
      check($sformatf("ev%0d_eidx", n_ev), g.eidx, e.eidx);
    end
  endtask

  // Monitor: bus transfers complete at the edge after a negedge with waitrequest low.
  initial begin
    int          hold  [2];
    logic        pdone [2];
    logic [50:0] saved [2];
    ev_t         g;
    hold  = '{0, 0};
    pdone = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          hold[d] = 0;
        end else begin
          check($sformatf("byteenable_dut%0d", d), be_s[d], (wr_s[d] || rd_s[d]) ? 4'hF : 4'h0);
          if (wr_s[d] || rd_s[d]) begin
            if (hold[d] > 0)
              check($sformatf("stall_stable_dut%0d", d), {wr_s[d], rd_s[d], addr_s[d], wd_s[d]}, saved[d]);
            saved[d] = {wr_s[d], rd_s[d], addr_s[d], wd_s[d]};
            hold[d]++;
            if (!wt_m[d]) begin
              g.dut = d; g.kind = wr_s[d] ? 0 : 1; g.addr = addr_s[d]; g.data = wd_s[d];
              g.hold = hold[d]; g.err = 1'b0; g.eidx = 8'h0;
              score(g);
              hold[d] = 0;
            end
          end else begin
            hold[d] = 0;
          end
          if (done_s[d] && !pdone[d]) begin
            g.dut = d; g.kind = 2; g.addr = 17'h0; g.data = 32'h0;
            g.hold = 0; g.err = error_s[d]; g.eidx = eidx_s[d];
            score(g);
          end
        end
        pdone[d] = done_s[d];
      end
    end
  end

  // Slave model for the verify instance: read data returns two edges after acceptance.
  initial begin
    int          cd;
    logic [16:0] raddr;
    cd = 0;
    raddr = '0;
    rdv_vf = 1'b0;
    rdata_vf = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_s[1] && !wt_vf) begin
        cd = 2;
        raddr = addr_s[1];
      end
      @(posedge clk);
      #2;
      rdv_vf = 1'b0;
      rdata_vf = '0;
      if (stray_req) begin
        rdv_vf = 1'b1;
        rdata_vf = 32'hDEAD_BEEF;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rdv_vf = 1'b1;
          for (int i = 0; i < 3; i++)
            if (a_ref[i] == raddr)
              rdata_vf = (corrupt && i == 2) ? 32'hDEAD_BEEF : d_ref[i];
        end
      end
    end
  end

  task automatic check_zero(input int d, input string tag);
    check({tag, "_flags"}, {done_s[d], error_s[d], wr_s[d], rd_s[d], be_s[d], eidx_s[d]}, 64'h0);
    check({tag, "_addr"}, addr_s[d], 17'h0);
    check({tag, "_wdata"}, wd_s[d], 32'h0);
  endtask

  // Raises start before edge 0 and returns just after edge 0 (cycle 1 begins).
  task automatic start_run(input int d);
    @(posedge clk); #1;
    if (d == 0) start_wo = 1'b1; else start_vf = 1'b1;
    @(posedge clk); #1;
    k0 = cyc_no;
  endtask

  task automatic wait_done(input int d, input int budget, output int cyc);
    int n;
    n = 0;
    while (!done_s[d] && n < budget) begin
      @(negedge clk);
      n++;
    end
    cyc = cyc_no - k0 + 1;
    check($sformatf("done_within_budget_dut%0d", d), done_s[d], 1'b1);
  endtask

  task automatic end_run(input int d);
    @(posedge clk); #1;
    if (d == 0) start_wo = 1'b0; else start_vf = 1'b0;
    @(negedge clk);
    check($sformatf("done_holds_dut%0d", d), done_s[d], 1'b1);
    @(negedge clk);
    check($sformatf("done_clears_dut%0d", d), {done_s[d], error_s[d]}, 2'b00);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start_wo = 1'b0; start_vf = 1'b0; wt_wo = 1'b0; wt_vf = 1'b0;
    stray_req = 1'b0; corrupt = 1'b0;
    #3;
    check_zero(0, "reset_wo");
    check_zero(1, "reset_vf");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Plain write-only run: writes on cycles 1..3, done from cycle 4.
    for (int i = 0; i < 3; i++) push(0, 0, i, 1, 1'b0, 8'h0);
    push(0, 2, 0, 0, 1'b0, 8'h0);
    start_run(0);
    wait_done(0, 50, cyc);
    check("wo_done_cycle", cyc, 4);
    end_run(0);

    // Entry 1 stalled for 5 cycles: held 6 cycles, done on cycle 9.
    push(0, 0, 0, 1, 1'b0, 8'h0);
    push(0, 0, 1, 6, 1'b0, 8'h0);
    push(0, 0, 2, 1, 1'b0, 8'h0);
    push(0, 2, 0, 0, 1'b0, 8'h0);
    start_run(0);
    @(posedge clk); #1 wt_wo = 1'b1;
    repeat (5) @(posedge clk);
    #1 wt_wo = 1'b0;
    wait_done(0, 50, cyc);
    check("stall_done_cycle", cyc, 9);
    end_run(0);

    // Waitrequest stuck on entry 0: 16 cycles of write, then error from cycle 17.
    wt_wo = 1'b1;
    push(0, 2, 0, 0, 1'b1, 8'h0);
    start_run(0);
    wait_done(0, 50, cyc);
    check("timeout_done_cycle", cyc, 17);
    check("timeout_bus_idle", {wr_s[0], rd_s[0]}, 2'b00);
    check("timeout_err_idx", eidx_s[0], 8'h0);
    wt_wo = 1'b0;
    end_run(0);

    // Reset while entry 1 is stalled, then restart from entry 0 with start still high.
    push(0, 0, 0, 1, 1'b0, 8'h0);
    start_run(0);
    @(posedge clk); #1 wt_wo = 1'b1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_zero(0, "midrun_reset");
    for (int i = 0; i < 3; i++) push(0, 0, i, 1, 1'b0, 8'h0);
    push(0, 2, 0, 0, 1'b0, 8'h0);
    @(posedge clk); #1 rst_n = 1'b1; wt_wo = 1'b0;
    wait_done(0, 50, cyc);
    end_run(0);

    // Verify run with matching read-back and a stray readdatavalid during the first write.
    for (int i = 0; i < 3; i++) begin
      push(1, 0, i, 1, 1'b0, 8'h0);
      push(1, 1, i, 1, 1'b0, 8'h0);
    end
    push(1, 2, 0, 0, 1'b0, 8'h0);
    start_run(1);
    stray_req = 1'b1;
    @(posedge clk); #1 stray_req = 1'b0;
    wait_done(1, 100, cyc);
    end_run(1);

    // Entry 2 reads back wrong: written twice, then error with err_idx 2.
    corrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(1, 0, i, 1, 1'b0, 8'h0);
      push(1, 1, i, 1, 1'b0, 8'h0);
    end
    push(1, 0, 2, 1, 1'b0, 8'h0);
    push(1, 1, 2, 1, 1'b0, 8'h0);
    push(1, 2, 0, 0, 1'b1, 8'h2);
    start_run(1);
    wait_done(1, 100, cyc);
    check("verify_err_flag", error_s[1], 1'b1);
    check("verify_err_idx", eidx_s[1], 8'h2);
    end_run(1);
    corrupt = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/aib_avmm_cfg_sequencer.md
AIB_AVMM_CFG_SEQUENCER -- requirements
Module: aib_avmm_cfg_sequencer

Interface
REQ-001 The block SHALL expose the following parameters, one per line below.
REQ-002 NUM_ENTRIES, 4, number of configuration writes in the table (1..256).
REQ-003 CFG_ADDR_TABLE, all-zero, NUM_ENTRIES*17-bit flat vector; entry i occupies bits [17*i+16:17*i].
REQ-004 CFG_DATA_TABLE, all-zero, NUM_ENTRIES*32-bit flat vector; entry i occupies bits [32*i+31:32*i].
REQ-005 VERIFY_EN, 0, 1 = read back and compare each entry after writing it.
REQ-006 MAX_RETRY, 3, mismatches allowed per entry before error (1..15).
REQ-007 TIMEOUT_CYCLES, 1024, maximum consecutive cycles spent in any bus state (2..65535).
REQ-008 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows (name  direction  width  meaning).
REQ-009 clk  in  1  sole clock; all state changes on rising edge.
REQ-010 rst_n  in  1  asynchronous active-low reset.
REQ-011 start  in  1  level request to run the sequence, held high by the calibration FSM.
REQ-012 done  out  1  sequence finished, successfully or with error.
REQ-013 error  out  1  sequence aborted on verify failure or timeout.
REQ-014 err_idx  out  8  index of the failing entry; valid while error=1.
REQ-015 avmm_address  out  17  Avalon-MM address.
REQ-016 avmm_writedata  out  32  Avalon-MM write data.
REQ-017 avmm_byteenable  out  4  constant 4'hF whenever write or read is asserted, else 4'h0.
REQ-018 avmm_write  out  1  write request.
REQ-019 avmm_read  out  1  read request.
REQ-020 avmm_readdata  in  32  read data.
REQ-021 avmm_readdatavalid  in  1  read data qualifier.
REQ-022 avmm_waitrequest  in  1  slave stall.

Function
REQ-023 All outputs SHALL be decoded from registered state, index, and flag values only, with no combinational path from any input to any output.
REQ-024 The states SHALL be IDLE, WRITE, RD_REQ, RD_WAIT, DONE, and ERR.
- IDLE: start=1 at an edge -> WRITE with idx=0 and retry=0.
- WRITE: assert avmm_write with address and data from entry idx. An edge with waitrequest=0 accepts the write.
  - If VERIFY_EN=1: go to RD_REQ.
  - Else if idx=NUM_ENTRIES-1: go to DONE.
  - Else: idx+1, stay in WRITE (back-to-back writes, 1 cycle each), retry=0.
- RD_REQ: assert avmm_read at the same address; writedata=0. An edge with waitrequest=0 -> RD_WAIT.
- RD_WAIT: avmm_read=0. At an edge with readdatavalid=1, compare readdata with the table data.
  - Match, not last: idx+1, retry=0 -> WRITE.
  - Match, last: -> DONE.
  - Mismatch: retry+1. If the new retry equals MAX_RETRY -> ERR, else -> WRITE with the same idx.
- DONE: done=1, error=0. start=0 -> IDLE.
- ERR: done=1, error=1, err_idx=idx. start=0 -> IDLE.
REQ-025 While avmm_waitrequest=1, avmm_write or avmm_read, avmm_address, and avmm_writedata SHALL be held stable.
REQ-026 A timeout counter SHALL clear on every state or idx change, and increment each cycle spent in WRITE, RD_REQ, or RD_WAIT; when it reaches TIMEOUT_CYCLES-1 with the state unchanged, the next state SHALL be ERR with bus requests deasserted.
REQ-027 The sequencer SHALL sample start only in IDLE, DONE, and ERR; deasserting start mid-sequence SHALL NOT abort it, and the sequence SHALL complete and then return to IDLE if start=0.
REQ-028 readdatavalid outside RD_WAIT SHALL be ignored.
REQ-029 Reaching DONE or ERR SHALL take priority over start; done SHALL stay high for at least one cycle.
REQ-030 Write-only latency with no stalls SHALL be as follows: start high at edge 0, writes on cycles 1..NUM_ENTRIES, done=1 from cycle NUM_ENTRIES+1.

Reset
REQ-031 While rst_n=0, the block SHALL force state=IDLE and idx, retry, timeout counter, done, error, err_idx, avmm_write, avmm_read, avmm_address, avmm_writedata, and avmm_byteenable to zero, immediately and asynchronously.
REQ-032 After rst_n release, any sequence in progress SHALL restart from entry 0 on the next start=1; no partial state SHALL be retained.

Verification
REQ-033 Run NUM_ENTRIES=3, VERIFY_EN=0, waitrequest=0, start=1 -> addresses A0, A1, A2 with write=1 on cycles 1-3, done=1 from cycle 4, error=0; start=0 -> done=0 next cycle.
REQ-034 Hold waitrequest=1 for 5 cycles on entry 1 -> write, address A1, and data D1 held 6 cycles; no entry skipped or repeated; done follows the last write.
REQ-035 Run VERIFY_EN=1 with readback equal to table data and readdatavalid 2 cycles after read acceptance -> per entry: 1 write, 1 read, compare, advance; done=1, error=0.
REQ-036 Run VERIFY_EN=1, MAX_RETRY=2, with entry 2 reading back 0xDEADBEEF versus table 0x00000001 -> entry 2 written twice, then done=1, error=1, err_idx=2.
REQ-037 Run TIMEOUT_CYCLES=16 with waitrequest stuck at 1 on entry 0 -> write=0 and done=1, error=1, err_idx=0 after 16 cycles in WRITE.
REQ-038 Pulse rst_n=0 during entry 1 -> all outputs 0 immediately; after release with start=1, the sequence restarts at A0.
